mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shared main-memory port controller for the cached pipeline. It arbitrates I-cache line fills, D-cache line fills and D-cache write-through stores onto one word-wide memory port. It sequences the multi-beat line transfers and returns completion pulses and a pipeline stall to the requesters. It sits between both caches and memory, and its completion pulses replace the ad-hoc complete1/complete2 handling in the hazard path.

## Interface

**Parameters**
- WORD_W, 16: data word width.
- ADDR_W, 16: word address width.
- LINE_WORDS, 4: words per cache line; must be a power of two and at least 2.

**Ports**
- clk, in, 1: clock; all state changes on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- i_req, in, 1: I-cache miss request; held high until i_done.
- i_addr, in, ADDR_W: I-miss address; the low log2(LINE_WORDS) bits are ignored.
- i_done, out, 1: one-cycle pulse; i_line is valid from this cycle.
- i_line, out, LINE_WORDS*WORD_W: filled line; word k is at bits [k*WORD_W +: WORD_W].
- d_req, in, 1: D-cache request; held high until d_done.
- d_we, in, 1: 1 = single-word store, 0 = line fill; sampled at grant.
- d_addr, in, ADDR_W: store address (full) or fill address (low bits ignored).
- d_wdata, in, WORD_W: store data; sampled at grant.
- d_done, out, 1: one-cycle completion pulse.
- d_line, out, LINE_WORDS*WORD_W: filled D line; same layout as i_line.
- mem_req, out, 1: beat request to memory.
- mem_we, out, 1: beat is a write.
- mem_addr, out, ADDR_W: beat word address.
- mem_wdata, out, WORD_W: write data.
- mem_ack, in, 1: memory accepted or completed the current beat; mem_rdata is valid in the same cycle.
- mem_rdata, in, WORD_W: read data.
- stall, out, 1: freeze the pipeline.

## Operation

**States:** IDLE, I_FILL, D_FILL, D_WRITE, DONE.

**IDLE → grant.** Grant is decided at a clock edge.
- Priority is d_req over i_req.
- Exception: if i_req was high throughout the previous D transaction, I wins the next grant. This is a one-bit `i_starved` flag; it is cleared whenever I is granted.
- At grant, latch the requester, the base address (low bits zeroed for fills), d_wdata, and d_we. Clear the beat counter `cnt`.
- Next state: D_FILL if d_we=0, D_WRITE if d_we=1, I_FILL for I.

**I_FILL / D_FILL.**
- mem_req=1, mem_we=0, mem_addr = {base[ADDR_W-1:log2 L], cnt}.
- On mem_ack: store mem_rdata into word `cnt` of the requester's line buffer and increment cnt.
- Ack on beat LINE_WORDS-1 → DONE.

**D_WRITE.**
- mem_req=1, mem_we=1, mem_addr = latched d_addr, mem_wdata = latched data.
- On mem_ack → DONE. d_line is not modified.

**DONE.**
- Pulse i_done or d_done for the granted requester only.
- mem_req=0. Requests are not sampled in this state.
- Next state is IDLE.

**Outputs and buffers.**
- mem_we, mem_addr and mem_wdata are 0 whenever mem_req=0.
- i_line and d_line hold their value until the next fill for the same requester overwrites them word by word.
- stall = (i_req | d_req) & (state != DONE). This is combinational.

**Boundary conditions.**
- Requests are read-only inputs during a transaction. A requester dropping req mid-transaction is illegal; the arbiter still completes the transfer and pulses done.
- A request arriving mid-transaction waits; stall stays high.
- mem_ack while mem_req=0 is ignored.
- Reset mid-transaction aborts it: state IDLE, cnt 0, i_starved 0, all outputs 0, and both line buffers cleared. Memory must tolerate a dropped mem_req.

## Timing

- Reset values: every output is 0, including both line buffers.
- Grant: registered. mem_req rises in the cycle after the edge where IDLE sees a request.
- Beats: one per cycle when memory acks every cycle; mem_addr advances in the cycle after each ack.
- Fill latency (request high → done), zero-wait memory: LINE_WORDS+2 cycles (grant, LINE_WORDS beats, DONE).
- Store latency, zero-wait memory: 3 cycles.
- Handshake: the requester sees done in cycle T and drops req for T+1. IDLE samples in T+1, so back-to-back requests have a 1-cycle IDLE gap.
- Both requests rising in the same cycle: D is served first, then I, with no further D grant in between.

## Test plan

1. Reset, then i_req with i_addr=0x0123, memory returning rdata = address with zero wait.
   → mem_addr steps 0x0120..0x0123; i_done at cycle 6; i_line = {0x0123, 0x0122, 0x0121, 0x0120}.
2. d_req with d_we=1, d_addr=0x0040, d_wdata=0xBEEF.
   → one beat with mem_we=1 and address 0x0040; d_done at cycle 3; d_line unchanged.
3. i_req and d_req (fill at 0x0200) raised together.
   → D fill completes first, then I fill; stall stays high until i_done, then drops.
4. D requests re-raised right after each d_done, with i_req held high.
   → I is granted immediately after the first D transaction completes (anti-starvation).
5. Memory inserting 2 wait cycles per beat on a fill.
   → address is held steady until ack; i_done at cycle 2 + 4×3.
6. reset asserted during beat 2 of a fill.
   → next cycle mem_req=0, state IDLE, no done pulse, lines cleared; a fresh request then restarts from beat 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-wide memory port between I-cache line fills,
// D-cache line fills and D-cache write-through stores. Line fills run as
// LINE_WORDS single-word beats; each transaction ends with a one-cycle done
// pulse to its requester. The pipeline is stalled while any request is
// outstanding.
module mem_arbiter #(
    parameter int WORD_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_req,
    input  logic [ADDR_W-1:0]            i_addr,
    output logic                         i_done,
    output logic [LINE_WORDS*WORD_W-1:0] i_line,
    input  logic                         d_req,
    input  logic                         d_we,
    input  logic [ADDR_W-1:0]            d_addr,
    input  logic [WORD_W-1:0]            d_wdata,
    output logic                         d_done,
    output logic [LINE_WORDS*WORD_W-1:0] d_line,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [WORD_W-1:0]            mem_wdata,
    input  logic                         mem_ack,
    input  logic [WORD_W-1:0]            mem_rdata,
    output logic                         stall
);

    localparam int                CNT_W    = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {IDLE, I_FILL, D_FILL, D_WRITE, DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               owner_d_q, owner_d_d;     // 1 = the D side owns the port
    logic               i_starved_q, i_starved_d; // I waited through a whole D transaction
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [WORD_W-1:0]  wdata_q, wdata_d;
    logic [WORD_W-1:0]  i_buf_q [LINE_WORDS];
    logic [WORD_W-1:0]  i_buf_d [LINE_WORDS];
    logic [WORD_W-1:0]  d_buf_q [LINE_WORDS];
    logic [WORD_W-1:0]  d_buf_d [LINE_WORDS];

    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               i_done_q, i_done_d;
    logic               d_done_q, d_done_d;

    // Next-state, buffer updates and registered output values derived from the next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d_d   = owner_d_q;
        i_starved_d = i_starved_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        i_buf_d     = i_buf_q;
        d_buf_d     = d_buf_q;

        case (state_q)
            IDLE: begin
                if (i_req && (i_starved_q || !d_req)) begin
                    state_d     = I_FILL;
                    owner_d_d   = 1'b0;
                    base_d      = i_addr & ~LOW_MASK;
                    cnt_d       = '0;
                    i_starved_d = 1'b0;
                end else if (d_req) begin
                    owner_d_d   = 1'b1;
                    cnt_d       = '0;
                    wdata_d     = d_wdata;
                    // Starvation tracking starts at the D grant and is narrowed every D beat cycle.
                    i_starved_d = i_req;
                    if (d_we) begin
                        state_d = D_WRITE;
                        base_d  = d_addr;
                    end else begin
                        state_d = D_FILL;
                        base_d  = d_addr & ~LOW_MASK;
                    end
                end
            end
            I_FILL, D_FILL: begin
                if (state_q == D_FILL) begin
                    i_starved_d = i_starved_q & i_req;
                end
                if (mem_ack) begin
                    if (state_q == I_FILL) begin
                        i_buf_d[cnt_q] = mem_rdata;
                    end else begin
                        d_buf_d[cnt_q] = mem_rdata;
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end
                end
            end
            D_WRITE: begin
                i_starved_d = i_starved_q & i_req;
                if (mem_ack) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        mem_req_d   = state_d inside {I_FILL, D_FILL, D_WRITE};
        mem_we_d    = (state_d == D_WRITE);
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (state_d == D_WRITE) begin
            mem_addr_d  = base_d;
            mem_wdata_d = wdata_d;
        end else if (mem_req_d) begin
            mem_addr_d  = base_d | ADDR_W'(cnt_d);
        end
        i_done_d = (state_d == DONE) && !owner_d_d;
        d_done_d = (state_d == DONE) && owner_d_d;
    end

    // All state and registered outputs; reset aborts any transfer and clears both lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_d_q   <= 1'b0;
            i_starved_q <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            for (int k = 0; k < LINE_WORDS; k++) begin
                i_buf_q[k] <= '0;
                d_buf_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_d_q   <= owner_d_d;
            i_starved_q <= i_starved_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_buf_q     <= i_buf_d;
            d_buf_q     <= d_buf_d;
        end
    end

    generate
        for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_line
            assign i_line[gi*WORD_W +: WORD_W] = i_buf_q[gi];
            assign d_line[gi*WORD_W +: WORD_W] = d_buf_q[gi];
        end
    endgenerate

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_done    = i_done_q;
    assign d_done    = d_done_q;
    // Combinational so the pipeline freezes in the same cycle a request rises.
    assign stall     = (i_req | d_req) & (state_q != DONE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed transactions against a behavioural
// transaction model plus a responding memory with optional wait states.
module tb_mem_arbiter;

    localparam int WW = 16;
    localparam int AW = 16;
    localparam int LW = 4;

    logic           clk;
    logic           reset;
    logic           i_req;
    logic [AW-1:0]  i_addr;
    logic           i_done;
    logic [LW*WW-1:0] i_line;
    logic           d_req;
    logic           d_we;
    logic [AW-1:0]  d_addr;
    logic [WW-1:0]  d_wdata;
    logic           d_done;
    logic [LW*WW-1:0] d_line;
    logic           mem_req;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [WW-1:0]  mem_wdata;
    logic           mem_ack;
    logic [WW-1:0]  mem_rdata;
    logic           stall;

    mem_arbiter #(.WORD_W(WW), .ADDR_W(AW), .LINE_WORDS(LW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_line(i_line),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_line(d_line),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // memory responder controls and write log
    int            wait_cfg = 0;
    int            wait_cnt = 0;
    bit            stray    = 0;
    int            wr_count = 0;
    logic [AW-1:0] wr_addr  = '0;
    logic [WW-1:0] wr_data  = '0;
    int            d_done_cnt = 0;

    // behavioural model: one outstanding transaction described by its fields
    bit            m_busy;
    bit            m_done;
    bit            m_is_d;
    bit            m_is_wr;
    int            m_beat;
    int            m_base;
    logic [AW-1:0] m_addr;
    logic [WW-1:0] m_wdata;
    bit            m_i_waited;
    logic [WW-1:0] m_iline [LW];
    logic [WW-1:0] m_dline [LW];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input bit want_d, input int start, output int lat);
        lat = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (want_d ? d_done : i_done) begin
                lat = cyc - start + 1;
                break;
            end
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL wait_%s: no done pulse within 200 cycles", want_d ? "d_done" : "i_done");
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Memory: acks after wait_cfg idle cycles per beat, returns the address as data.
    initial begin
        mem_ack   = 0;
        mem_rdata = 16'hDEAD;
        forever begin
            @(posedge clk);
            #3;
            if (mem_req === 1'b1) begin
                if (wait_cnt >= wait_cfg) begin
                    mem_ack   = 1;
                    mem_rdata = mem_addr;
                    wait_cnt  = 0;
                    if (mem_we) begin
                        wr_count++;
                        wr_addr = mem_addr;
                        wr_data = mem_wdata;
                    end
                end else begin
                    mem_ack   = 0;
                    mem_rdata = 16'hDEAD;
                    wait_cnt++;
                end
            end else begin
                mem_ack   = stray;
                mem_rdata = 16'hDEAD;
                wait_cnt  = 0;
            end
        end
    end

    // Reference model: advances one transaction per clock edge from the sampled inputs.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_busy = 0; m_done = 0; m_is_d = 0; m_is_wr = 0; m_beat = 0;
                m_base = 0; m_addr = '0; m_wdata = '0; m_i_waited = 0;
                for (int k = 0; k < LW; k++) begin
                    m_iline[k] = '0;
                    m_dline[k] = '0;
                end
            end else if (m_done) begin
                m_done = 0;
            end else if (m_busy) begin
                if (m_is_d) m_i_waited = m_i_waited && i_req;
                if (mem_ack) begin
                    if (m_is_wr) begin
                        m_busy = 0;
                        m_done = 1;
                    end else begin
                        if (m_is_d) m_dline[m_beat] = mem_rdata;
                        else        m_iline[m_beat] = mem_rdata;
                        m_beat++;
                        if (m_beat == LW) begin
                            m_busy = 0;
                            m_done = 1;
                        end
                    end
                end
            end else if (i_req && (m_i_waited || !d_req)) begin
                m_busy = 1; m_is_d = 0; m_is_wr = 0; m_beat = 0;
                m_base = int'(i_addr) - (int'(i_addr) % LW);
                m_i_waited = 0;
            end else if (d_req) begin
                m_busy = 1; m_is_d = 1; m_is_wr = d_we; m_beat = 0;
                m_base = int'(d_addr) - (int'(d_addr) % LW);
                m_addr = d_addr;
                m_wdata = d_wdata;
                m_i_waited = i_req;
            end
        end
    end

    // Compare every cycle against the model, away from the clock edge.
    initial begin
        logic [LW*WW-1:0] exp_i, exp_d;
        logic [AW-1:0]    exp_addr;
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < LW; k++) begin
                exp_i[k*WW +: WW] = m_iline[k];
                exp_d[k*WW +: WW] = m_dline[k];
            end
            exp_addr = !m_busy ? '0 : (m_is_wr ? m_addr : AW'(m_base + m_beat));
            check("mem_req", mem_req, m_busy);
            check("mem_we", mem_we, m_busy && m_is_wr);
            check("mem_addr", mem_addr, exp_addr);
            check("mem_wdata", mem_wdata, (m_busy && m_is_wr) ? m_wdata : '0);
            check("i_done", i_done, m_done && !m_is_d);
            check("d_done", d_done, m_done && m_is_d);
            check("stall", stall, (i_req || d_req) && !m_done);
            check("i_line", i_line, exp_i);
            check("d_line", d_line, exp_d);
            if (d_done) d_done_cnt++;
        end
    end

    // Directed transactions with hand-computed expectations.
    initial begin
        int lat, start, dcnt0;
        bit found;
        reset = 1; i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        repeat (3) tick();
        reset = 0;
        @(negedge clk);
        check("reset_i_line", i_line, 64'h0);
        check("reset_mem_req", {mem_req, mem_we, i_done, d_done}, 4'b0000);

        // 1: I fill at 0x0123, zero-wait memory
        tick(); i_req = 1; i_addr = 16'h0123; start = cyc;
        wait_done(0, start, lat);
        check("t1_latency", lat, 6);
        check("t1_i_line", i_line, 64'h0123_0122_0121_0120);
        $display("txn I fill addr=0123 latency=%0d line=%h", lat, i_line);
        tick(); i_req = 0;

        // stray acks while idle must be ignored
        stray = 1; tick(); tick(); stray = 0;

        // 2: D store 0xBEEF to 0x0040
        tick(); d_req = 1; d_we = 1; d_addr = 16'h0040; d_wdata = 16'hBEEF; start = cyc;
        wait_done(1, start, lat);
        check("t2_latency", lat, 3);
        check("t2_d_line", d_line, 64'h0);
        check("t2_wr_log", {wr_count[15:0], wr_addr, wr_data}, {16'd1, 16'h0040, 16'hBEEF});
        $display("txn D store addr=0040 data=BEEF latency=%0d", lat);
        tick(); d_req = 0;

        // 3: simultaneous D fill and I fill
        tick(); d_req = 1; d_we = 0; d_addr = 16'h0200; i_req = 1; i_addr = 16'h0300; start = cyc;
        wait_done(1, start, lat);
        check("t3_d_latency", lat, 6);
        check("t3_d_line", d_line, 64'h0203_0202_0201_0200);
        $display("txn D fill addr=0200 latency=%0d line=%h", lat, d_line);
        tick(); d_req = 0;
        wait_done(0, start, lat);
        check("t3_i_latency", lat, 12);
        check("t3_i_line", i_line, 64'h0303_0302_0301_0300);
        $display("txn I fill addr=0300 latency=%0d line=%h", lat, i_line);
        tick(); i_req = 0;
        @(negedge clk);
        check("t3_stall_drop", stall, 1'b0);

        // 4: D re-requests immediately; starved I must win the next grant
        tick(); i_req = 1; i_addr = 16'h0400; d_req = 1; d_we = 1; d_addr = 16'h0050; d_wdata = 16'h1111;
        start = cyc;
        wait_done(1, start, lat);
        check("t4_d1_latency", lat, 3);
        $display("txn D store addr=0050 data=1111 latency=%0d", lat);
        tick(); d_addr = 16'h0060; d_wdata = 16'h2222;
        dcnt0 = d_done_cnt;
        wait_done(0, start, lat);
        check("t4_i_latency", lat, 9);
        $display("txn I fill addr=0400 latency=%0d line=%h", lat, i_line);
        tick(); i_req = 0; start = cyc;
        check("t4_no_d_between", d_done_cnt - dcnt0, 0);
        wait_done(1, start, lat);
        check("t4_d2_latency", lat, 3);
        check("t4_wr_log", {wr_addr, wr_data}, {16'h0060, 16'h2222});
        $display("txn D store addr=0060 data=2222 latency=%0d", lat);
        tick(); d_req = 0;

        // 5: two wait cycles per beat
        wait_cfg = 2;
        tick(); i_req = 1; i_addr = 16'h0502; start = cyc;
        wait_done(0, start, lat);
        check("t5_latency", lat, 14);
        check("t5_i_line", i_line, 64'h0503_0502_0501_0500);
        $display("txn I fill addr=0502 waits=2 latency=%0d line=%h", lat, i_line);
        tick(); i_req = 0;
        wait_cfg = 0;

        // 6: reset during beat 2, then restart from beat 0
        tick(); i_req = 1; i_addr = 16'h0600;
        found = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 16'h0601) begin
                found = 1;
                break;
            end
        end
        check("t6_reach_beat1", found, 1'b1);
        tick(); reset = 1;
        @(negedge clk);
        check("t6_beat2_addr", mem_addr, 16'h0602);
        tick(); reset = 0; start = cyc;
        @(negedge clk);
        check("t6_abort_outputs", {mem_req, i_done, d_done}, 3'b000);
        check("t6_i_line_cleared", i_line, 64'h0);
        check("t6_d_line_cleared", d_line, 64'h0);
        wait_done(0, start, lat);
        check("t6_latency", lat, 6);
        check("t6_i_line", i_line, 64'h0603_0602_0601_0600);
        $display("txn I fill after reset addr=0600 latency=%0d line=%h", lat, i_line);
        tick(); i_req = 0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
